// File: rtl/ofdm_symbol_framer.sv
// OFDM symbol framer: drops preamble, passes LTS, strips CP and frames FFT_LEN data symbols.
// Optional restart on mid-packet trigger: define OFDM_FRAMER_RETRIGGER_EN.
module ofdm_symbol_framer #(
    parameter int         WIDTH_SAMPLE   = 16,
    parameter int         WIDTH_PHASE    = 32,
    parameter int         FFT_LEN        = 64,
    parameter int         CP_LEN         = 16,
    parameter int         SKIP_LEN       = 192,
    parameter int         NUM_LTS        = 2,
    parameter logic [7:0] SR_NUM_SYMBOLS = 8'd6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      set_stb,
    input  logic [7:0]                set_addr,
    input  logic [31:0]               set_data,
    input  logic [2*WIDTH_SAMPLE-1:0] sample_in_tdata,
    input  logic                      sample_in_tlast,
    input  logic                      sample_in_tvalid,
    output logic                      sample_in_tready,
    input  logic [WIDTH_PHASE-1:0]    phase_in_tdata,
    input  logic                      phase_in_tvalid,
    output logic                      phase_in_tready,
    output logic [2*WIDTH_SAMPLE-1:0] o_tdata,
    output logic                      o_tlast,
    output logic [1:0]                o_tuser,
    output logic                      o_tvalid,
    input  logic                      o_tready,
    output logic [WIDTH_PHASE-1:0]    phase_out_tdata,
    output logic                      phase_out_tvalid,
    input  logic                      phase_out_tready
);

    localparam int LTS_LEN = NUM_LTS * FFT_LEN;
    localparam int CNT_MAX = (SKIP_LEN > LTS_LEN) ? SKIP_LEN : LTS_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FFT_W   = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SKIP,
        S_LTS,
        S_CP,
        S_DATA
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
    logic [9:0]        sym_reg, sym_next, sym_inc;
    logic [9:0]        num_symbols_reg;
    logic [9:0]        num_active_reg, num_active_next;

    logic              o_valid_reg;
    logic              o_last_reg;
    logic [1:0]        o_user_reg;
    logic              phase_valid_reg;
    logic [WIDTH_PHASE-1:0] phase_data_reg;

    logic              trig_beat;
    logic              pass_state;
    logic              out_free;
    logic              phase_free;
    logic              sample_ready;
    logic              accept;
    logic              restart;
    logic              out_load;
    logic              out_last;
    logic [1:0]        out_user;
    logic              phase_load;

    assign trig_beat  = sample_in_tvalid & sample_in_tlast;
    assign pass_state = (state_reg == S_LTS) || (state_reg == S_DATA);
    assign out_free   = ~o_valid_reg | o_tready;
    assign phase_free = ~phase_valid_reg | phase_out_tready;

    assign sample_in_tready = sample_ready;
    assign phase_in_tready  = trig_beat & sample_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_symbols_reg <= '0;
        end else if (set_stb && (set_addr == SR_NUM_SYMBOLS)) begin
            num_symbols_reg <= set_data[9:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            sym_reg        <= '0;
            num_active_reg <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            sym_reg        <= sym_next;
            num_active_reg <= num_active_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        sym_next        = sym_reg;
        num_active_next = num_active_reg;
        cnt_inc         = cnt_reg + CNT_W'(1);
        sym_inc         = sym_reg + 10'd1;
        sample_ready    = 1'b0;
        out_load        = 1'b0;
        out_last        = 1'b0;
        out_user        = 2'b00;
        phase_load      = 1'b0;
        restart         = 1'b0;

        // Trigger beats carry a phase beat; pass-state beats need the output slot.
        if (!reset) begin
            if (trig_beat) begin
                if (state_reg == S_IDLE) begin
                    sample_ready = phase_in_tvalid & phase_free;
                end else begin
`ifdef OFDM_FRAMER_RETRIGGER_EN
                    sample_ready = phase_in_tvalid & phase_free & (~pass_state | out_free);
`else
                    sample_ready = phase_in_tvalid & (~pass_state | out_free);
`endif
                end
            end else begin
                sample_ready = ~pass_state | out_free;
            end
        end

        accept = sample_in_tvalid & sample_ready;

`ifdef OFDM_FRAMER_RETRIGGER_EN
        restart = trig_beat & (state_reg != S_IDLE);
`endif

        if (accept) begin
            if (restart) begin
                phase_load      = 1'b1;
                num_active_next = num_symbols_reg;
                cnt_next        = '0;
                state_next      = S_SKIP;
                if (pass_state) begin
                    out_load = 1'b1;
                    out_last = 1'b1;
                    out_user = {1'b1, state_reg == S_LTS};
                end
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (trig_beat) begin
                            phase_load      = 1'b1;
                            num_active_next = num_symbols_reg;
                            cnt_next        = '0;
                            state_next      = S_SKIP;
                        end
                    end
                    S_SKIP: begin
                        if (cnt_reg == CNT_W'(SKIP_LEN - 1)) begin
                            cnt_next   = '0;
                            state_next = S_LTS;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end
                    S_LTS: begin
                        out_load = 1'b1;
                        out_user = 2'b01;
                        out_last = &cnt_reg[FFT_W-1:0];
                        if (cnt_reg == CNT_W'(LTS_LEN - 1)) begin
                            cnt_next   = '0;
                            sym_next   = '0;
                            state_next = S_CP;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end
                    S_CP: begin
                        if (cnt_reg == CNT_W'(CP_LEN - 1)) begin
                            cnt_next   = '0;
                            state_next = S_DATA;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end
                    S_DATA: begin
                        out_load = 1'b1;
                        if (cnt_reg == CNT_W'(FFT_LEN - 1)) begin
                            out_last = 1'b1;
                            cnt_next = '0;
                            sym_next = sym_inc;
                            // A zero count means unlimited; sym simply wraps.
                            if ((num_active_reg != 10'd0) && (sym_inc == num_active_reg)) begin
                                state_next = S_IDLE;
                            end else begin
                                state_next = S_CP;
                            end
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end
                    default: begin
                        state_next = S_IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end
        end
    end

    // Output register: loads only when the slot is free, so data holds under stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_valid_reg <= 1'b0;
            o_last_reg  <= 1'b0;
            o_user_reg  <= 2'b00;
        end else if (out_free) begin
            o_valid_reg <= out_load;
            if (out_load) begin
                o_last_reg <= out_last;
                o_user_reg <= out_user;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [WIDTH_SAMPLE-1:0] lane_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    lane_reg <= '0;
                end else if (out_free && out_load) begin
                    lane_reg <= sample_in_tdata[gi*WIDTH_SAMPLE +: WIDTH_SAMPLE];
                end
            end
            assign o_tdata[gi*WIDTH_SAMPLE +: WIDTH_SAMPLE] = lane_reg;
        end
    endgenerate

    assign o_tvalid = o_valid_reg;
    assign o_tlast  = o_last_reg;
    assign o_tuser  = o_user_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_valid_reg <= 1'b0;
            phase_data_reg  <= '0;
        end else if (phase_load) begin
            phase_valid_reg <= 1'b1;
            phase_data_reg  <= phase_in_tdata;
        end else if (phase_out_tready) begin
            phase_valid_reg <= 1'b0;
        end
    end

    assign phase_out_tdata  = phase_data_reg;
    assign phase_out_tvalid = phase_valid_reg;

endmodule
